// File: rtl/mem_responder.sv
// Byte-wide memory responder with programmable wait states, one-cycle ready pulse
// and a side preload port. RAM is 2^AW bytes and is never cleared by reset.
module mem_responder #(
  parameter int AW          = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] adr,
  input  logic [7:0]    writedata,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_adr,
  input  logic [7:0]    ld_data,
  output logic [7:0]    memdata,
  output logic          ready,
  output logic          busy,
  output logic          err
);

  // state  | meaning
  // IDLE   | accepts preloads and new requests
  // WAIT   | counting down wait states on the latched request
  // DONE   | ready pulse (err too if the request was illegal)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          is_wr_q, is_wr_d;
  logic          illegal_q, illegal_d;
  logic [7:0]    memdata_q, memdata_d;
  logic [7:0]    mem_q [0:(1<<AW)-1];

  logic          done_entry;
  logic [AW-1:0] acc_adr;
  logic [7:0]    acc_wdata;
  logic          acc_wr;
  logic          load_now;

  assign load_now = (state_q == S_IDLE) && ld_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    illegal_d  = illegal_q;
    done_entry = 1'b0;
    acc_adr    = adr_q;
    acc_wdata  = wdata_q;
    acc_wr     = is_wr_q;
    case (state_q)
      S_IDLE: begin
        if (!ld_en) begin
          if (memread && memwrite) begin
            state_d   = S_DONE;
            illegal_d = 1'b1;
          end else if (memread || memwrite) begin
            adr_d     = adr;
            wdata_d   = writedata;
            is_wr_d   = memwrite;
            illegal_d = 1'b0;
            cnt_d     = WS;
            // Zero wait states: complete on the acceptance edge using the live inputs.
            if (WS == 4'd0) begin
              state_d    = S_DONE;
              done_entry = 1'b1;
              acc_adr    = adr;
              acc_wdata  = writedata;
              acc_wr     = memwrite;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_DONE;
          done_entry = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    memdata_d = memdata_q;
    if (done_entry && !acc_wr) memdata_d = mem_q[acc_adr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      adr_q     <= '0;
      wdata_q   <= 8'h00;
      is_wr_q   <= 1'b0;
      illegal_q <= 1'b0;
      memdata_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      illegal_q <= illegal_d;
      memdata_q <= memdata_d;
    end
  end

  // RAM has no reset; writes are blocked while rst is held so an aborted access never lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_now)
        mem_q[ld_adr] <= ld_data;
      else if (done_entry && acc_wr)
        mem_q[acc_adr] <= acc_wdata;
    end
  end

  assign memdata = memdata_q;
  assign ready   = (state_q == S_DONE);
  assign err     = (state_q == S_DONE) && illegal_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-wide memory responder that services the multicycle controller's memory requests (memread/memwrite with the datapath's byte address and write data). Holds program and data in an internal RAM of 2^AW bytes. Inserts a programmable number of wait states and signals completion with a one-cycle ready pulse, so the controller can stall on slow memory. A side load port preloads program bytes before or between accesses.

## Interface
- AW, 8, address width; RAM depth is 2^AW bytes
- WAIT_STATES, 2, extra cycles between acceptance and completion; legal range 0..15
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- memread  input  1  read request; held by requester until ready
- memwrite  input  1  write request; held by requester until ready
- adr  input  AW  byte address of request
- writedata  input  8  byte to write
- ld_en  input  1  preload strobe, one byte per cycle
- ld_adr  input  AW  preload address
- ld_data  input  8  preload byte
- memdata  output  8  registered read data; holds last completed read
- ready  output  1  one-cycle completion pulse
- busy  output  1  high whenever state is not IDLE
- err  output  1  one-cycle pulse: illegal request (memread and memwrite both high)

## Operation
- States: IDLE, WAIT, DONE.
- IDLE, ld_en=1: write ld_data to RAM[ld_adr]; stay IDLE. Load has priority over a pending request, which stays pending.
- IDLE, ld_en=0, exactly one of memread/memwrite high: accept. Latch adr, writedata and request type. Load counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else DONE.
- IDLE, memread and memwrite both high: go to DONE flagged illegal. No RAM access; memdata unchanged.
- WAIT: decrement counter each cycle. When counter reaches 1, go to DONE on the next edge. ld_en ignored; request inputs ignored (latched copies used).
- Transition into DONE:
  - legal write: RAM[latched adr] <= latched writedata
  - legal read: memdata <= RAM[latched adr]
- DONE: ready=1 for this cycle only; err=1 if flagged illegal. Unconditionally go to IDLE.
- Requester must drop its request in the cycle after ready, else the request is re-accepted as a new access.
- Addresses are AW bits; no out-of-range case. Address 2^AW-1 is an ordinary location.
- RAM contents are not cleared by reset.

## Timing
- Reset values: state IDLE, counter 0, memdata 8'h00, ready 0, busy 0, err 0.
- Acceptance edge = cycle 0. ready is high during cycle WAIT_STATES+1. For WAIT_STATES=0, ready is high during cycle 1.
- memdata is valid in the ready cycle and held until the next legal read completes.
- Minimum spacing between acceptances is WAIT_STATES+2 cycles, because DONE always returns to IDLE.
- busy is high from cycle 1 through the ready cycle inclusive.
- Reset asserted in WAIT or DONE aborts the access:
  - a write whose DONE-entry edge has not occurred is not performed
  - ready and err are forced low immediately (asynchronous)
- A load into the same address as a pending request in IDLE completes first; the subsequent read returns the loaded byte.

## Test plan
- Reset: assert rst mid-run -> memdata=00, ready=0, busy=0, err=0 immediately; state IDLE after release.
- WAIT_STATES=2: write 8'hA5 to 8'h10 (accepted cycle 0) -> ready only in cycle 3, busy cycles 1-3. Then read 8'h10 -> ready in cycle 3 with memdata=A5; memdata holds A5 afterwards.
- WAIT_STATES=0: preload 8'h3C at 8'hFF via ld_en, then read 8'hFF -> ready in cycle 1 with memdata=3C. Back-to-back held read re-accepted every 2 cycles.
- Illegal request: memread=memwrite=1, adr 8'h20, writedata 8'h77 -> ready and err both pulse once. RAM[8'h20] unchanged (read back old value); memdata unchanged.
- Load/request collision: ld_en=1 with ld_adr 8'h05, ld_data 8'h9E, and memread for 8'h05 in the same IDLE cycle -> load performed, read accepted next cycle, returns 9E.
- Reset mid-write: write 8'h11 to 8'h40 with WAIT_STATES=3, pulse rst in cycle 2 -> no ready. Subsequent read of 8'h40 returns the prior contents, not 11.
